// File: rtl/cache_line_fill_ctrl_pkg.sv
// Shared constants and state encoding for the I-cache line fill controller.
// Build option CACHE_CRITICAL_FIRST_EN is consumed by cache_line_fill_ctrl.
package cache_line_fill_ctrl_pkg;

  localparam int CACHE_LINES      = 32;
  localparam int CACHE_LINE_BYTES = 16;
  localparam int CACHE_OFF_W      = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/cache_line_fill_ctrl_one_hot_5_bit.sv
// 5->32 one-hot tag decoder used to set a single line valid bit.
module one_hot_5_bit (
  input  logic [4:0]  sel,
  output logic [31:0] onehot
);

  assign onehot = 32'd1 << sel;

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// I-cache line fill FSM and valid-bit store (32 lines x 16 bytes).
// CACHE_CRITICAL_FIRST_EN: start the fill at the missed byte and wrap.
module cache_line_fill_ctrl
  import cache_line_fill_ctrl_pkg::*;
#(
  parameter int LINE_BITS = 5,
  parameter int BYTE_BITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           lookup_valid,
  input  logic [LINE_BITS+BYTE_BITS-1:0] lookup_offset,
  output logic                           hit,
  output logic                           busy,
  output logic                           mem_req,
  output logic [LINE_BITS+BYTE_BITS-1:0] mem_addr,
  input  logic                           mem_ack,
  input  logic [7:0]                     mem_data,
  output logic                           cache_we,
  output logic [LINE_BITS+BYTE_BITS-1:0] cache_waddr,
  output logic [7:0]                     cache_wdata,
  output logic [(1<<LINE_BITS)-1:0]      line_valid,
  output logic                           fill_done
);

  localparam int OW = LINE_BITS + BYTE_BITS;
  localparam int NL = 1 << LINE_BITS;
  localparam int NB = 1 << BYTE_BITS;
  localparam logic [BYTE_BITS:0] LAST_ACK = (BYTE_BITS+1)'(NB - 1);

  fill_state_t state, state_nx;

  logic [LINE_BITS-1:0] fill_line, fill_line_nx;
  logic [BYTE_BITS-1:0] byte_cnt, byte_cnt_nx;
  logic [BYTE_BITS:0]   acks_left, acks_left_nx;
  logic [NL-1:0]        line_valid_nx;
  logic [NL-1:0]        line_sel;
  logic [BYTE_BITS-1:0] start_byte;
  logic                 miss;

  one_hot_5_bit u_dec (
    .sel    (fill_line),
    .onehot (line_sel)
  );

  assign hit  = lookup_valid
              & line_valid[lookup_offset[OW-1:BYTE_BITS]];
  assign miss = lookup_valid & ~hit & ~flush;
  assign busy = (state != IDLE);

`ifdef CACHE_CRITICAL_FIRST_EN
  assign start_byte = lookup_offset[BYTE_BITS-1:0];
`else
  assign start_byte = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fill_line  <= '0;
      byte_cnt   <= '0;
      acks_left  <= '0;
      line_valid <= '0;
    end else begin
      state      <= state_nx;
      fill_line  <= fill_line_nx;
      byte_cnt   <= byte_cnt_nx;
      acks_left  <= acks_left_nx;
      line_valid <= line_valid_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    fill_line_nx  = fill_line;
    byte_cnt_nx   = byte_cnt;
    acks_left_nx  = acks_left;
    line_valid_nx = line_valid;
    mem_req       = 1'b0;
    mem_addr      = '0;
    cache_we      = 1'b0;
    cache_waddr   = '0;
    cache_wdata   = '0;
    fill_done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss) begin
          fill_line_nx = lookup_offset[OW-1:BYTE_BITS];
          byte_cnt_nx  = start_byte;
          acks_left_nx = '0;
          state_nx     = FILL;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {fill_line, byte_cnt};
        if (mem_ack) begin
          // a coincident flush still lets the byte land in RAM
          cache_we     = ~reset;
          cache_waddr  = {fill_line, byte_cnt};
          cache_wdata  = mem_data;
          byte_cnt_nx  = byte_cnt + 1'b1;
          acks_left_nx = acks_left + 1'b1;
          if (acks_left == LAST_ACK)
            state_nx = DONE;
        end
      end
      DONE: begin
        fill_done     = ~reset & ~flush;
        line_valid_nx = line_valid | line_sel;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      line_valid_nx = '0;
      state_nx      = IDLE;
    end
  end

endmodule

// File: doc/cache_line_fill_ctrl.md
# cache_line_fill_ctrl

Fill controller and valid-bit store for the 512-byte instruction cache: 32 lines × 16 bytes. On a lookup miss it fetches the 16 bytes of the missed line from the memory interface, writes them into the cache RAM, then sets that line's valid bit. The valid bit is set through the 5→32 one-hot tag decoder, driven by the latched line number. Sits between the fetch unit (lookups, flushes) and the cache RAM / memory arbiter.

## Interface
- `LINE_BITS`, default 5: line index width; 32 lines.
- `BYTE_BITS`, default 4: byte-in-line width; 16 bytes.
- `clk` input, 1: sole clock; all state changes on rising edge.
- `reset` input, 1: synchronous, active-high.
- `flush` input, 1: clears all valid bits and aborts any fill.
- `lookup_valid` input, 1: lookup request this cycle.
- `lookup_offset` input, 9: cache-relative byte offset; `[8:4]` is the line, `[3:0]` is the byte.
- `hit` output, 1: `lookup_valid & line_valid[lookup_offset[8:4]]`, combinational.
- `busy` output, 1: state ≠ IDLE.
- `mem_req` output, 1: byte fetch request, held until acknowledged.
- `mem_addr` output, 9: cache-relative offset of the requested byte; the arbiter adds the cache base.
- `mem_ack` input, 1: data valid on `mem_data`; only meaningful while `mem_req` is high.
- `mem_data` input, 8: fetched byte.
- `cache_we` output, 1: cache RAM write strobe.
- `cache_waddr` output, 9: RAM write address.
- `cache_wdata` output, 8: RAM write data.
- `line_valid` output, 32: registered valid bits.
- `fill_done` output, 1: one-cycle pulse when a line becomes valid.

## Operation
- States: IDLE, FILL, DONE. Encoding: 2 bits, binary.
- **IDLE**
  - On `lookup_valid & ~hit & ~flush`, latch the line number in `fill_line` and the start byte in `byte_cnt` (see Configuration).
  - Clear `acks_left` to 0, then go to FILL.
  - A lookup that hits does nothing.
- **FILL**
  - `mem_req` = 1 and `mem_addr` = `{fill_line, byte_cnt}`.
  - On `mem_ack`: `cache_we` = 1, `cache_waddr` = `mem_addr`, and `cache_wdata` = `mem_data`, all combinational in the same cycle.
  - Then `byte_cnt` increments modulo 16 (wraps 15→0) and `acks_left` increments.
  - On the 16th ack, go to DONE.
  - Lookups during FILL are not accepted for filling; `hit` still reports the current valid bits.
- **DONE**
  - `fill_done` = 1.
  - `line_valid` ← `line_valid | onehot(fill_line)`.
  - Go to IDLE.
- **flush**, in any state: `line_valid` ← 0 and state ← IDLE.
  - Takes priority over the DONE set and over a miss start in the same cycle.
  - In FILL, the RAM write of a coincident ack still happens (`cache_we` = 1), but the line is never marked valid.
- `mem_ack` while `mem_req` = 0 is ignored.
- `hit` never reports a partially filled line valid.

## Timing
- Reset values:
  - State IDLE.
  - `line_valid` = 0.
  - `fill_line`, `byte_cnt` and `acks_left` = 0.
  - All outputs 0: `mem_req`, `cache_we`, `fill_done`, `busy` and `hit` (given `line_valid` = 0), and the address/data outputs.
- Reset has priority over flush.
- Reset mid-fill drops `mem_req` the next cycle, and no write occurs in the reset cycle.
- Miss seen in cycle N gives `mem_req` high in cycle N+1.
- Zero-wait memory (ack every cycle):
  - Acks in cycles N+1 … N+16.
  - DONE and `fill_done` in N+17.
  - `line_valid` bit visible and `hit` possible in N+18.
- Wait states extend FILL one cycle each. `mem_addr` is stable while `mem_req` is high and unacknowledged.
- A back-to-back miss to another line can start in N+18 at the earliest.

## Configuration
- `CACHE_CRITICAL_FIRST_EN` defined: the fill starts at `lookup_offset[3:0]` and wraps through 15→0 until 16 bytes are written.
- `CACHE_CRITICAL_FIRST_EN` undefined: the fill always starts at byte 0 and ends at byte 15.
- Latency, valid-bit behaviour and flush semantics are identical in both builds.

## Structure
- Shared cache header/package holds:
  - `CACHE_LINES` = 32 and `CACHE_LINE_BYTES` = 16.
  - Cache offset width = 9.
  - State encodings IDLE=0, FILL=1, DONE=2.
- Sub-module: one instance of `one_hot_5_bit`, selector = `fill_line`. Its output is ORed into `line_valid` in DONE.
- Fill FSM, counters and valid register live in this block.

## Test plan
- **Reset and idle:** assert `reset` 2 cycles, then lookup at offset 0x000 → `hit` = 0, `line_valid` = 0; after release, miss starts and `mem_req` = 1 next cycle with `mem_addr` = 0x000.
- **Full fill, zero-wait:** miss at 0x1A5, `mem_data` = byte index → 16 writes to 0x1A0–0x1AF; `fill_done` at N+17; `line_valid` = 0x0400_0000; lookup 0x1AC hits at N+18.
- **Critical-first wrap** (macro defined): miss at 0x03D → write order 0x03D, 0x03E, 0x03F, 0x030 … 0x03C; `line_valid[3]` set.
  - Macro undefined: order is 0x030 … 0x03F.
- **Wait states:** ack every 3rd cycle → `mem_addr` stable between acks; exactly 16 writes; `fill_done` at N+1+48.
- **Flush mid-fill:** flush after the 7th ack, with lines 0 and 31 already valid → `line_valid` = 0 next cycle; state IDLE; `fill_done` never pulses; a new lookup of the same line misses and refills.
- **Simultaneous events:** flush in the DONE cycle → line not set, `line_valid` = 0; stray `mem_ack` in IDLE → no `cache_we`.
